// File: rtl/amber_regcr_rev_if.sv
// rtl/amber_regcr_rev_if.sv - read/write/revocation bus of the amber capability register file
interface amber_regcr_rev_if #(
  parameter int NUM_CR = 4,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = 48,
  parameter int PERM_W = 24,
  parameter int ATTR_W = 24
);
  localparam int IDX_W = $clog2(NUM_CR);
  localparam int CAP_W = 3*ADDR_W + PERM_W + ATTR_W + 1;

  logic [NUM_RD*IDX_W-1:0] iw_rd_idx;
  logic [NUM_RD*CAP_W-1:0] ow_rd_cap;
  logic                    iw_wr_en;
  logic [IDX_W-1:0]        iw_wr_idx;
  logic [5:0]              iw_wr_mask;
  logic [CAP_W-1:0]        iw_wr_cap;
  logic                    iw_rev_start;
  logic [ADDR_W-1:0]       iw_rev_lo;
  logic [ADDR_W-1:0]       iw_rev_hi;
  logic                    ow_rev_busy;
  logic                    ow_rev_done;
  logic [IDX_W:0]          ow_rev_count;

  modport master (
    output iw_rd_idx, iw_wr_en, iw_wr_idx, iw_wr_mask, iw_wr_cap,
           iw_rev_start, iw_rev_lo, iw_rev_hi,
    input  ow_rd_cap, ow_rev_busy, ow_rev_done, ow_rev_count
  );

  modport slave (
    input  iw_rd_idx, iw_wr_en, iw_wr_idx, iw_wr_mask, iw_wr_cap,
           iw_rev_start, iw_rev_lo, iw_rev_hi,
    output ow_rd_cap, ow_rev_busy, ow_rev_done, ow_rev_count
  );
endinterface

// File: rtl/amber_regcr_rev.sv
// rtl/amber_regcr_rev.sv - capability register file with masked write, read bypass and revocation sweep
module amber_regcr_rev #(
  parameter int NUM_CR   = 4,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = 48,
  parameter int PERM_W   = 24,
  parameter int ATTR_W   = 24,
  parameter bit ROOT_CR0 = 1'b1
) (
  input  logic             iw_clk,
  input  logic             iw_rst,
  amber_regcr_rev_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CR);
  localparam int CNT_W = IDX_W + 1;
  localparam int CAP_W = 3*ADDR_W + PERM_W + ATTR_W + 1;
  localparam int TAG_B = CAP_W - 1;

  localparam logic [CAP_W-1:0] ROOT_CAP = {1'b1, {ATTR_W{1'b0}}, {PERM_W{1'b1}},
                                           {ADDR_W{1'b0}}, {ADDR_W{1'b1}}, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CAP_W-1:0]   cap_q [NUM_CR];
  logic [CAP_W-1:0]   cap_d [NUM_CR];

  logic [CAP_W-1:0]   wr_fmask;
  logic [ADDR_W-1:0]  scan_base;
  logic               scan_tag;
  logic               scan_hit;
  logic               wr_tag_same;
  logic               clear_en;

  assign wr_fmask = {bus.iw_wr_mask[5], {ATTR_W{bus.iw_wr_mask[4]}}, {PERM_W{bus.iw_wr_mask[3]}},
                     {ADDR_W{bus.iw_wr_mask[2]}}, {ADDR_W{bus.iw_wr_mask[1]}},
                     {ADDR_W{bus.iw_wr_mask[0]}}};

  // The sweep always compares against stored (pre-write) base and tag.
  assign scan_base   = cap_q[idx_q][ADDR_W-1:0];
  assign scan_tag    = cap_q[idx_q][TAG_B];
  assign scan_hit    = (state_q == S_SCAN) && scan_tag && (scan_base >= lo_q) && (scan_base < hi_q);
  assign wr_tag_same = bus.iw_wr_en && bus.iw_wr_mask[5] && (bus.iw_wr_idx == idx_q);
  assign clear_en    = scan_hit && !wr_tag_same;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.iw_rev_start) begin
          state_d = S_SCAN;
          idx_d   = '0;
          lo_d    = bus.iw_rev_lo;
          hi_d    = bus.iw_rev_hi;
          count_d = '0;
        end
      end
      S_SCAN: begin
        idx_d = idx_q + IDX_W'(1);
        if (clear_en && (count_q != CNT_W'(NUM_CR))) begin
          count_d = count_q + CNT_W'(1);
        end
        if (idx_q == IDX_W'(NUM_CR - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CR; i++) begin
      cap_d[i] = cap_q[i];
      if (bus.iw_wr_en && (bus.iw_wr_idx == IDX_W'(i))) begin
        cap_d[i] = (cap_q[i] & ~wr_fmask) | (bus.iw_wr_cap & wr_fmask);
      end
      if (clear_en && (idx_q == IDX_W'(i))) begin
        cap_d[i][TAG_B] = 1'b0;
      end
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_CR; i++) begin
        cap_q[i] <= ((i == 0) && ROOT_CR0) ? ROOT_CAP : '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_CR; i++) begin
        cap_q[i] <= cap_d[i];
      end
    end
  end

  assign bus.ow_rev_busy  = (state_q == S_SCAN);
  assign bus.ow_rev_done  = (state_q == S_DONE);
  assign bus.ow_rev_count = count_q;

  // Masked fields of a same-cycle write to the read index come straight from the write bus.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [IDX_W-1:0] ridx;
    logic [CAP_W-1:0] bmask;
    assign ridx  = bus.iw_rd_idx[p*IDX_W +: IDX_W];
    assign bmask = (bus.iw_wr_en && (bus.iw_wr_idx == ridx)) ? wr_fmask : '0;
    assign bus.ow_rd_cap[p*CAP_W +: CAP_W] = ({1'b0, ridx} < CNT_W'(NUM_CR))
        ? ((cap_q[ridx] & ~bmask) | (bus.iw_wr_cap & bmask)) : '0;
  end
endmodule

// File: doc/amber_regcr_rev.md
Name: amber_regcr_rev

Overview:
Parametrised capability register file for the amber core, generalising the fixed 4-entry CR file. Each entry holds base, len, cur, perms, attr and tag.
- NUM_RD combinational read ports.
- One field-masked write port.
- Built-in revocation sweep FSM: clears the tag of every live capability whose base lies in a revoked address range, one entry per cycle.

Parameters:
NUM_CR, 4, number of capability registers (>=2)
NUM_RD, 2, number of read ports
ADDR_W, 48, width of base/len/cur
PERM_W, 24, width of perms
ATTR_W, 24, width of attr
ROOT_CR0, 1, if 1 CR0 resets to root capability, else to null
IDX_W and CAP_W are derived localparams: IDX_W=clog2(NUM_CR), CAP_W=3*ADDR_W+PERM_W+ATTR_W+1.

Ports:
iw_clk  in  1  clock
iw_rst  in  1  reset, asynchronous, active-high
iw_rd_idx  in  NUM_RD*IDX_W  read indices, port p at [p*IDX_W +: IDX_W]
ow_rd_cap  out  NUM_RD*CAP_W  read data, packed {tag,attr,perms,cur,len,base}, tag at MSB
iw_wr_en  in  1  write enable
iw_wr_idx  in  IDX_W  write index
iw_wr_mask  in  6  field enables {tag,attr,perms,cur,len,base}
iw_wr_cap  in  CAP_W  write data, same packing
iw_rev_start  in  1  start revocation sweep (pulse)
iw_rev_lo  in  ADDR_W  revoked range low bound, inclusive
iw_rev_hi  in  ADDR_W  revoked range high bound, exclusive
ow_rev_busy  out  1  sweep in progress
ow_rev_done  out  1  one-cycle pulse at sweep completion
ow_rev_count  out  IDX_W+1  number of tags cleared by the last sweep

Behaviour:
- Reset (async, all entries):
  - Entries 1..NUM_CR-1 and CR0 when ROOT_CR0=0 reset to all fields 0, tag 0.
  - CR0 when ROOT_CR0=1 resets to base 0, len all-ones, cur 0, perms all-ones, attr 0, tag 1.
  - Outputs at reset: ow_rev_busy=0, ow_rev_done=0, ow_rev_count=0. FSM state = IDLE.
- Reads:
  - Combinational from stored state.
  - Same-cycle write bypass: fields with iw_wr_en=1, iw_wr_idx==rd_idx and mask bit set come from iw_wr_cap; other fields come from storage.
  - A tag clear by the sweep is visible to reads from the following cycle.
  - Out-of-range index (>=NUM_CR) reads as all zero.
- Writes:
  - On posedge with iw_wr_en=1, update only the masked fields of entry iw_wr_idx.
  - Out-of-range index: write ignored.
- Sweep FSM, states IDLE, SCAN, DONE:
  - IDLE: on iw_rev_start, latch lo/hi, scan index:=0, count:=0, go to SCAN. ow_rev_done=0.
  - SCAN: ow_rev_busy=1. Each cycle evaluates entry[idx]. If tag==1 and lo<=base<hi (unsigned), the tag clears at the clock edge and count increments. idx increments. After idx==NUM_CR-1 is evaluated, go to DONE.
  - DONE: ow_rev_busy=0, ow_rev_done=1 for exactly one cycle, then IDLE.
  - Latency: start sampled at edge t; SCAN occupies cycles t..t+NUM_CR-1 after the edge; done is high in the cycle after the last scan. Total start-to-done = NUM_CR+1 edges.
  - ow_rev_count holds its value from DONE until the next accepted start.
- Boundary rules:
  - iw_rev_start while in SCAN or DONE: ignored; the latched range is unchanged.
  - Empty range (lo>=hi): sweep still runs the full NUM_CR cycles; count=0; no tags change.
  - Write and scan hit the same entry in the same cycle:
    - If the write mask includes tag, the write wins: stored tag = written tag and count does not increment.
    - If the write mask excludes tag, the sweep clear applies. The other written fields still update, and the sweep compares against the pre-write base.
  - Entries already scanned and written afterwards are not re-checked. Entries written before their scan are checked with their new value.
  - Reset asserted mid-sweep: FSM returns to IDLE immediately, busy/done/count=0, all entries take reset values.
- Arithmetic: range compare is unsigned ADDR_W-bit. The count register saturates at NUM_CR and cannot overflow.

Test Plan:
1. Reset with ROOT_CR0=1 -> rd_cap[CR0] = base 0, len 0xFFFFFFFFFFFF, perms 0xFFFFFF, tag 1; CR1..3 all zero; busy=0, count=0.
2. Masked write to CR2 with mask=6'b000100 (cur only), cur=105 -> only CR2.cur=105; base/len/perms unchanged. Same-cycle read of CR2 shows 105 via bypass.
3. CR1 base=100 tag=1, CR2 base=200 tag=1, CR3 base=50 tag=1; sweep lo=100, hi=200:
   - CR1 tag->0, CR2 and CR3 keep tag=1, CR0 (base 0) keeps tag=1.
   - busy high for 4 cycles; done pulses at the 5th edge; count=1.
4. Same setup; a tag=1 write to CR1 lands in CR1's scan cycle -> CR1.tag=1, count=0. Repeat with mask excluding tag -> CR1.tag=0, count=1.
5. Second iw_rev_start during SCAN with lo=0, hi=max -> ignored; result identical to scenario 3. Empty range lo=hi=100 -> count=0, done after 5 edges.
6. Assert iw_rst in the 2nd SCAN cycle -> busy=0, count=0 immediately. After release, a new sweep completes normally.
